// File: rtl/regfile.sv
// Two-read, one-write register file with a hardwired zero register.
// Reads are combinational; an optional bypass forwards same-cycle write data.
module regfile #(
   parameter int WIDTH  = 32,
   parameter int ADDR   = 5,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [ADDR-1:0]  ReadRegister1,
   input  logic [ADDR-1:0]  ReadRegister2,
   input  logic [ADDR-1:0]  WriteRegister,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             RegWrite,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2
);

   localparam int NREG = 1 << ADDR;

   // Register 0 has no storage, so its decoder output is never built.
   logic [NREG-1:1]  wr_en_s;
   logic [WIDTH-1:0] data_r [1:NREG-1];
   logic [WIDTH-1:0] q_s    [0:NREG-1];

   function automatic logic [WIDTH-1:0] read_port(
      input logic [ADDR-1:0]  raddr,
      input logic [WIDTH-1:0] stored,
      input logic             live,
      input logic             we,
      input logic [ADDR-1:0]  waddr,
      input logic [WIDTH-1:0] wdata
   );
      logic [WIDTH-1:0] r;
      r = '0;
      // raddr != 0 together with raddr == waddr already excludes writes to r0.
      if (!live || raddr == '0) begin
         r = '0;
      end else if (BYPASS != 0 && we && raddr == waddr) begin
         r = wdata;
      end else begin
         r = stored;
      end
      return r;
   endfunction

   // One-hot write enable decode
   always_comb begin
      wr_en_s = '0;
      for (int k = 1; k < NREG; k++) begin
         wr_en_s[k] = RegWrite && (WriteRegister == ADDR'(k));
      end
   end

   // Storage for registers 1..NREG-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 1; k < NREG; k++) begin
            data_r[k] <= '0;
         end
      end else begin
         for (int k = 1; k < NREG; k++) begin
            if (wr_en_s[k]) begin
               data_r[k] <= WriteData;
            end
         end
      end
   end

   // Array view with the zero register in slot 0
   always_comb begin
      q_s[0] = '0;
      for (int k = 1; k < NREG; k++) begin
         q_s[k] = data_r[k];
      end
   end

   // Two independent read ports
   always_comb begin
      ReadData1 = read_port(ReadRegister1, q_s[ReadRegister1], reset_n,
                            RegWrite, WriteRegister, WriteData);
      ReadData2 = read_port(ReadRegister2, q_s[ReadRegister2], reset_n,
                            RegWrite, WriteRegister, WriteData);
   end

endmodule

// File: tb/tb_regfile.sv
// Directed, table-driven bench for regfile; a second instance with BYPASS=0
// covers the old-data-on-collision behaviour.
module tb_regfile;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] wd;
   logic        we;
   logic [31:0] rd1, rd2, nb_rd1, nb_rd2;

   int total = 0;
   int bad   = 0;

   regfile #(.WIDTH(32), .ADDR(5), .BYPASS(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .ReadRegister1(ra1), .ReadRegister2(ra2), .WriteRegister(wa),
      .WriteData(wd), .RegWrite(we),
      .ReadData1(rd1), .ReadData2(rd2)
   );

   regfile #(.WIDTH(32), .ADDR(5), .BYPASS(0)) dut_nb (
      .clk(clk), .reset_n(reset_n),
      .ReadRegister1(ra1), .ReadRegister2(ra2), .WriteRegister(wa),
      .WriteData(wd), .RegWrite(we),
      .ReadData1(nb_rd1), .ReadData2(nb_rd2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
      we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
   endtask

   initial begin
      // Each entry is applied after a falling edge and checked before the next
      // rising edge, which then performs the write.
      vecs[0]  = '{1'b1, 5'd5,  32'h00FFFAAA, 5'd5,  5'd5,  32'h00FFFAAA, 32'h00FFFAAA};
      vecs[1]  = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd6,  32'h00FFFAAA, 32'h00000000};
      vecs[2]  = '{1'b0, 5'd5,  32'h00FFF000, 5'd5,  5'd5,  32'h00FFFAAA, 32'h00FFFAAA};
      vecs[3]  = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'h00FFFAAA, 32'h00FFFAAA};
      vecs[4]  = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
      vecs[5]  = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd5,  32'h00000000, 32'h00FFFAAA};
      vecs[6]  = '{1'b1, 5'd7,  32'h11111111, 5'd1,  5'd2,  32'h00000000, 32'h00000000};
      vecs[7]  = '{1'b1, 5'd7,  32'h22222222, 5'd7,  5'd8,  32'h22222222, 32'h00000000};
      vecs[8]  = '{1'b0, 5'd0,  32'h00000000, 5'd7,  5'd7,  32'h22222222, 32'h22222222};
      vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd31, 32'h00000000, 32'hCAFEF00D};
      vecs[10] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd7,  32'h12345678, 32'h22222222};
      vecs[11] = '{1'b0, 5'd0,  32'h00000000, 5'd31, 5'd31, 32'h12345678, 32'h12345678};
      vecs[12] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd1,  32'hA5A5A5A5, 32'h00000000};
      vecs[13] = '{1'b0, 5'd0,  32'h00000000, 5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};

      reset_n = 1'b0;
      drive(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5);
      #2;
      chk("reset_hold_p1", rd1, 32'h0);
      chk("reset_hold_p2", rd2, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i);
         ra2 = 5'(31 - i);
         #1;
         chk($sformatf("reset_read_p1[%0d]", i), rd1, 32'h0);
         chk($sformatf("reset_read_p2[%0d]", 31 - i), rd2, 32'h0);
      end

      for (int v = 0; v < 14; v++) begin
         @(negedge clk);
         drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
         #2;
         chk($sformatf("vec%0d_p1", v), rd1, vecs[v].exp1);
         chk($sformatf("vec%0d_p2", v), rd2, vecs[v].exp2);
      end

      // Registers not written so far must remain zero.
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd30);
      #2;
      chk("untouched_r6", rd1, 32'h0);
      chk("untouched_r30", rd2, 32'h0);

      // Without bypass a colliding read sees the old value, new value next cycle.
      @(negedge clk);
      drive(1'b1, 5'd9, 32'h00000055, 5'd9, 5'd3);
      #2;
      chk("nb_collide_old", nb_rd1, 32'h0);
      chk("nb_other_port", nb_rd2, 32'hA5A5A5A5);
      chk("byp_collide_new", rd1, 32'h00000055);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      #2;
      chk("nb_after_edge", nb_rd1, 32'h00000055);
      chk("byp_after_edge", rd2, 32'h00000055);

      // Asynchronous reset between edges.
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
      #2;
      chk("pre_reset_r3", rd1, 32'hA5A5A5A5);
      chk("pre_reset_r31", rd2, 32'h12345678);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_reset_p1", rd1, 32'h0);
      chk("async_reset_p2", rd2, 32'h0);
      drive(1'b1, 5'd3, 32'h77777777, 5'd3, 5'd3);
      #1;
      chk("reset_bypass_off", rd1, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
      #2;
      chk("post_reset_r3", rd1, 32'h0);
      chk("post_reset_r31", rd2, 32'h0);
      ra1 = 5'd7;
      ra2 = 5'd9;
      #1;
      chk("post_reset_r7", rd1, 32'h0);
      chk("post_reset_nb_r9", nb_rd2, 32'h0);

      // First write after release lands on the next rising edge.
      @(negedge clk);
      drive(1'b1, 5'd3, 32'h0BADF00D, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      #2;
      chk("rewrite_r3_p1", rd1, 32'h0BADF00D);
      chk("rewrite_r3_nb", nb_rd2, 32'h0BADF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
